// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a byte FIFO
// with sticky framing-error flag and saturating overflow counter.
module uart_rx_capture #(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [7:0]                    rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic [7:0]                    ovf_cnt,
  input  logic                          err_clr
);
  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LP_HALF_END = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] LP_BIT_END  = 16'(BAUD_DIV - 1);
  localparam logic [AW:0] LP_FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          r_sync1, r_sync2, r_rxd_prev;
  state_t        r_state, w_state_nxt;
  logic [15:0]   r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_frame_err;
  logic [7:0]    r_ovf_cnt;

  logic w_rxd_s, w_fall, w_half_hit, w_bit_hit;
  logic w_cnt_clr, w_sample, w_push, w_ferr_set;
  logic w_pop, w_full, w_accept, w_drop;

  // Synchroniser; the third flop only remembers the previous synced level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync1    <= rxd;
      r_sync2    <= r_sync1;
      r_rxd_prev <= r_sync2;
    end
  end

  assign w_rxd_s    = r_sync2;
  assign w_fall     = r_rxd_prev & ~w_rxd_s;
  assign w_half_hit = (r_baud_cnt == LP_HALF_END);
  assign w_bit_hit  = (r_baud_cnt == LP_BIT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_START;
      S_START: if (w_half_hit) w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_hit && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_hit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr  = 1'b0;
    w_sample   = 1'b0;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      S_IDLE:  w_cnt_clr = w_fall;
      S_START: w_cnt_clr = w_half_hit;
      S_DATA: begin
        w_cnt_clr = w_bit_hit;
        w_sample  = w_bit_hit;
      end
      S_STOP: begin
        w_cnt_clr  = w_bit_hit;
        w_push     = w_bit_hit & w_rxd_s;
        w_ferr_set = w_bit_hit & ~w_rxd_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end else begin
      if (w_cnt_clr)              r_baud_cnt <= '0;
      else if (r_state != S_IDLE) r_baud_cnt <= r_baud_cnt + 16'd1;
      if (r_state == S_START)     r_bit_idx  <= '0;
      else if (w_sample)          r_bit_idx  <= r_bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sample) r_shift[r_bit_idx] <= w_rxd_s;
  end

  // A full FIFO still accepts a byte when the head leaves on the same edge
  assign w_full   = (r_level == LP_FULL);
  assign w_pop    = rx_valid & rx_ready;
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // Error events take priority over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_ovf_cnt   <= '0;
    end else begin
      if (w_ferr_set)   r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
      if (w_drop) begin
        if (err_clr)                 r_ovf_cnt <= 8'd1;
        else if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end else if (err_clr) begin
        r_ovf_cnt <= '0;
      end
    end
  end

  assign rx_valid  = (r_level != '0);
  assign rx_data   = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign rx_level  = r_level;
  assign frame_err = r_frame_err;
  assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Randomised scoreboard bench for uart_rx_capture: a frame-level model predicts
// accepted bytes and error flags; a monitor compares every FIFO handshake.
module tb_uart_rx_capture;
  localparam int BAUD      = 16;
  localparam int DEPTH     = 16;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int NONE      = -1000;
  // Edge (counted from the start-bit drive) on which the stop bit is judged:
  // 2 sync + 1 edge detect + half bit + 8 data bits + 1 stop bit
  localparam int PUSH_EDGE = 3 + BAUD / 2 + 9 * BAUD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [LW-1:0] rx_level;
  logic          frame_err;
  logic [7:0]    ovf_cnt;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ferr = 1'b0;
  int         exp_ovf = 0;
  logic       rdy_rand = 1'b0;

  uart_rx_capture #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_level(rx_level), .frame_err(frame_err), .ovf_cnt(ovf_cnt),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, int'(frame_err), int'(exp_ferr));
    chk({tag, "_ovf_cnt"}, int'(ovf_cnt), exp_ovf);
  endtask

  // Drives one 8N1 frame; pop_edge/clr_edge raise rx_ready/err_clr for exactly that edge
  task automatic send(input logic [7:0] b, input logic stop, input int pop_edge, input int clr_edge);
    logic [9:0] bits;
    int cyc;
    logic dropped;
    bits = {stop, b, 1'b0};
    cyc = 0;
    dropped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < BAUD; k++) begin
        @(negedge clk);
        if (k == 0) rxd = bits[i];
        if (i == 9 && k == 0) begin
          if (!stop) exp_ferr = 1'b1;
          else if (exp_q.size() < DEPTH || pop_edge == PUSH_EDGE) exp_q.push_back(b);
          else begin
            dropped = 1'b1;
            if (exp_ovf < 255) exp_ovf++;
          end
        end
        if (rdy_rand) rx_ready = 1'($urandom_range(0, 1));
        if (cyc == pop_edge - 1) rx_ready = 1'b1;
        if (cyc == pop_edge) rx_ready = 1'b0;
        if (cyc == clr_edge - 1) begin
          err_clr = 1'b1;
          // The clear lands on the stop-bit edge, so this frame's own event survives it
          exp_ferr = !stop;
          exp_ovf = dropped ? 1 : 0;
        end
        if (cyc == clr_edge) err_clr = 1'b0;
        cyc++;
      end
    end
    @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf = 0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    @(negedge clk) rx_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_drained"}, int'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    chk({tag, "_level_after_drain"}, int'(rx_level), 0);
  endtask

  // Monitor: handshake compare, head stability under backpressure, valid/level agreement
  logic       held = 1'b0;
  logic [7:0] held_data = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("valid_vs_level", int'(rx_valid), int'(rx_level != '0));
        if (held && rx_valid) chk("head_stable", int'(rx_data), int'(held_data));
        held = rx_valid && !rx_ready;
        held_data = rx_data;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
          end else begin
            chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] abort_bits;
    repeat (3) @(negedge clk);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_level", int'(rx_level), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_ovf_cnt", int'(ovf_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two back-to-back known frames
    rx_ready = 1'b1;
    send(8'h55, 1'b1, NONE, NONE);
    send(8'hA3, 1'b1, NONE, NONE);
    repeat (4) @(negedge clk);
    chk("basic_all_received", int'(exp_q.size()), 0);
    check_flags("basic");

    // Random bytes with random consumer backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'b1, NONE, NONE);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    rdy_rand = 1'b0;
    drain("random");
    check_flags("random");

    // Short low glitch must be rejected
    @(negedge clk) rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_level", int'(rx_level), 0);
    check_flags("glitch");

    // Framing error, recovery, clear
    send(8'h3C, 1'b0, NONE, NONE);
    repeat (3) @(negedge clk);
    chk("ferr_no_push_level", int'(rx_level), 0);
    check_flags("ferr_set");
    repeat (10) @(negedge clk);
    send(8'h7E, 1'b1, NONE, NONE);
    repeat (4) @(negedge clk);
    chk("ferr_recover_received", int'(exp_q.size()), 0);
    pulse_clr();
    check_flags("ferr_cleared");

    // Clear coinciding with a framing error: the error wins
    send(8'h3C, 1'b0, NONE, PUSH_EDGE);
    repeat (2) @(negedge clk);
    check_flags("clr_vs_ferr");
    pulse_clr();

    // Overflow: 18 bytes into a 16-deep FIFO with no consumer
    rx_ready = 1'b0;
    for (int i = 0; i < 18; i++) send(8'(i), 1'b1, NONE, NONE);
    repeat (2) @(negedge clk);
    chk("ovf_level", int'(rx_level), DEPTH);
    chk("ovf_head", int'(rx_data), int'(exp_q[0]));
    check_flags("ovf");
    drain("ovf");
    check_flags("ovf_after_drain");
    pulse_clr();
    check_flags("ovf_cleared");

    // Full FIFO with a pop exactly on the push edge
    rx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b1, NONE, NONE);
    chk("full_level", int'(rx_level), DEPTH);
    send(8'h10, 1'b1, PUSH_EDGE, NONE);
    repeat (2) @(negedge clk);
    chk("push_pop_full_level", int'(rx_level), DEPTH);
    check_flags("push_pop_full");
    drain("push_pop_full");

    // Reset mid-frame with bytes queued and an error flagged
    rx_ready = 1'b0;
    send(8'h3C, 1'b0, NONE, NONE);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1, NONE, NONE);
    chk("pre_reset_level", int'(rx_level), 3);
    abort_bits = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 5 * BAUD + BAUD / 2; c++) begin
      @(negedge clk);
      if (c % BAUD == 0) rxd = abort_bits[c / BAUD];
    end
    @(negedge clk);
    rst_n = 1'b0;
    rxd = 1'b1;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf = 0;
    #1;
    chk("midreset_rx_valid", int'(rx_valid), 0);
    chk("midreset_rx_data", int'(rx_data), 0);
    chk("midreset_rx_level", int'(rx_level), 0);
    check_flags("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BAUD * 10) @(negedge clk);
    chk("post_reset_idle_level", int'(rx_level), 0);
    rx_ready = 1'b1;
    send(8'h42, 1'b1, NONE, NONE);
    repeat (4) @(negedge clk);
    chk("post_reset_received", int'(exp_q.size()), 0);
    check_flags("post_reset");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", int'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 217, clk cycles per UART bit (25 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rxd  input  1  serial line from the SoC uart_tx pin, idle high, asynchronous to clk.
REQ-006 SHALL have port rx_valid  output  1  FIFO non-empty; rx_data is valid.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts the head byte when rx_valid&rx_ready.
REQ-008 SHALL have port rx_data  output  8  FIFO head byte.
REQ-009 SHALL have port rx_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port frame_err  output  1  sticky flag: stop bit sampled low.
REQ-011 SHALL have port ovf_cnt  output  8  saturating count of bytes dropped because the FIFO was full.
REQ-012 SHALL have port err_clr  input  1  single-cycle pulse clearing frame_err and ovf_cnt.

Function
REQ-013 SHALL synchronise rxd through two flops (rxd_s); all decisions use rxd_s; input-to-decision latency is 2 cycles.
REQ-014 SHALL implement FSM IDLE, START, DATA, STOP with a 16-bit baud counter and a 3-bit bit index.
REQ-015 IDLE: SHALL move to START and clear the baud counter only on a falling edge of rxd_s (previous 1, current 0); a line held low SHALL NOT start a frame.
REQ-016 START: at baud count BAUD_DIV/2-1 (integer division), rxd_s=0 -> DATA with counter cleared; rxd_s=1 -> IDLE (glitch reject, nothing recorded).
REQ-017 DATA: at count BAUD_DIV-1, SHALL sample rxd_s into bit[index], LSB first, clear counter, increment index; after bit 7 -> STOP.
REQ-018 STOP: at count BAUD_DIV-1, rxd_s=1 -> push byte to FIFO; rxd_s=0 -> set frame_err, discard byte; both -> IDLE.
REQ-019 Push when FIFO full and no pop in the same cycle SHALL drop the byte and increment ovf_cnt, saturating at 255.
REQ-020 Push and pop in the same cycle SHALL both take effect; a push into a full FIFO with a simultaneous pop is accepted, rx_level unchanged.
REQ-021 rx_valid SHALL equal (rx_level!=0); rx_data SHALL be the oldest entry, stable while rx_valid&!rx_ready.
REQ-022 A pushed byte SHALL appear on rx_valid/rx_data the cycle after the push (1-cycle FIFO latency).
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; rx_level SHALL never exceed FIFO_DEPTH nor underflow (pop while empty ignored).
REQ-024 err_clr SHALL clear frame_err and ovf_cnt next cycle; if a set/increment event coincides with err_clr, the event wins (frame_err=1, ovf_cnt=1).

Reset
REQ-025 With rst_n low: FSM=IDLE, counters=0, sync flops=1, FIFO empty, rx_valid=0, rx_data=0, rx_level=0, frame_err=0, ovf_cnt=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; after release, reception restarts only on a fresh falling edge.

Verification
REQ-027 BAUD_DIV=16, rx_ready=1, send 0x55 then 0xA3 (8N1) -> rx_valid pulses twice with 0x55, 0xA3; frame_err=0, ovf_cnt=0.
REQ-028 BAUD_DIV=16, rxd low 4 cycles then high -> START rejects glitch, rx_level stays 0, no flags.
REQ-029 BAUD_DIV=16, send 0x3C with stop bit low -> no push, frame_err=1; line high then 0x7E -> 0x7E received; err_clr -> frame_err=0.
REQ-030 FIFO_DEPTH=16, rx_ready=0, send 18 bytes 0x00..0x11 -> rx_level=16, ovf_cnt=2; draining yields 0x00..0x0F in order.
REQ-031 FIFO full, rx_ready=1 asserted exactly in the push cycle of byte 0x10 -> byte accepted, rx_level stays 16, ovf_cnt unchanged.
REQ-032 rst_n pulsed low during bit 4 of a frame with 3 bytes queued -> all outputs at reset values; next clean frame 0x42 received correctly.
